// File: rtl/ram_boot_loader.sv
// Boot loader for the 256x16 data RAM: assembles a framed byte stream into words,
// writes them from address 0 upward, and hands the RAM port to the CPU once a frame checks out.
module ram_boot_loader #(
  parameter int          ADDR_W = 8,
  parameter int          DATA_W = 16,
  parameter logic [7:0]  MAGIC  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              ram_mem_read,
  output logic              ram_mem_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_stall,
  output logic              load_done,
  output logic              load_error,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    LO    = 3'd2,
    HI    = 3'd3,
    WRITE = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6,
    ERROR = 3'd7
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W:0]   wptr, n_words, wptr_inc;
  logic [7:0]        sum, lo, hi;
  logic              accept, is_magic, waiting;

  // Handshake: a byte moves when rx_valid and rx_ready are both high on a rising edge.
  assign rx_ready  = (state != WRITE);
  assign accept    = rx_valid && rx_ready;
  assign is_magic  = (rx_data == MAGIC);
  assign waiting   = (state == IDLE) || (state == DONE) || (state == ERROR);
  assign wptr_inc  = wptr + {{ADDR_W{1'b0}}, 1'b1};
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERROR: if (accept && is_magic) state_nx = COUNT;
      COUNT:             if (accept) state_nx = LO;
      LO:                if (accept) state_nx = HI;
      HI:                if (accept) state_nx = WRITE;
      WRITE:             state_nx = (wptr_inc == n_words) ? CHECK : LO;
      CHECK:             if (accept) state_nx = (rx_data == sum) ? DONE : ERROR;
      default:           state_nx = IDLE;
    endcase
  end

  // RAM port belongs to the CPU only in DONE; otherwise the loader drives it.
  always_comb begin
    cpu_stall     = 1'b1;
    ram_mem_read  = 1'b0;
    ram_mem_write = 1'b0;
    ram_addr      = '0;
    ram_wdata     = '0;
    if (state == DONE) begin
      cpu_stall     = 1'b0;
      ram_mem_read  = cpu_mem_read;
      ram_mem_write = cpu_mem_write;
      ram_addr      = cpu_addr;
      ram_wdata     = cpu_wdata;
    end else if (state == WRITE) begin
      ram_mem_write = 1'b1;
      ram_addr      = wptr[ADDR_W-1:0];
      ram_wdata     = {hi, lo};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wptr       <= '0;
      n_words    <= '0;
      sum        <= '0;
      lo         <= '0;
      hi         <= '0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state <= state_nx;
      if (waiting && accept && is_magic) begin
        wptr       <= '0;
        sum        <= '0;
        load_done  <= 1'b0;
        load_error <= 1'b0;
      end
      case (state)
        // A count byte of zero stands for a full 256-word image.
        COUNT: if (accept) n_words <= (rx_data == 8'd0) ? (ADDR_W+1)'(256)
                                                         : (ADDR_W+1)'(rx_data);
        LO: if (accept) begin
          lo  <= rx_data;
          sum <= sum + rx_data;
        end
        HI: if (accept) begin
          hi  <= rx_data;
          sum <= sum + rx_data;
        end
        WRITE: wptr <= wptr_inc;
        CHECK: if (accept) begin
          load_done  <= (rx_data == sum);
          load_error <= (rx_data != sum);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_boot_loader.sv
// Directed bench for ram_boot_loader: feeds frames, models the RAM behind the port,
// and checks handshake, port mux and status flags against hand-computed values.
module tb_ram_boot_loader;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_HI    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERROR = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        cpu_mem_read = 1'b0;
  logic        cpu_mem_write = 1'b0;
  logic [7:0]  cpu_addr = 8'h00;
  logic [15:0] cpu_wdata = 16'h0000;
  logic        ram_mem_read, ram_mem_write;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        cpu_stall, load_done, load_error;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] mem [256];
  int          wr_count = 0;
  logic [7:0]  last_wr_addr = 8'h00;
  int          base;

  ram_boot_loader dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .ram_mem_read(ram_mem_read), .ram_mem_write(ram_mem_write),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .cpu_stall(cpu_stall), .load_done(load_done), .load_error(load_error),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // RAM model: captures on the rising edge whenever memWrite is high.
  always @(posedge clk) begin
    if (!rst && ram_mem_write) begin
      mem[ram_addr] <= ram_wdata;
      last_wr_addr  <= ram_addr;
      wr_count++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Loader-owned write cycles must never accept a byte.
  always @(negedge clk) begin
    if (!rst && ram_mem_write && cpu_stall)
      chk("ready_in_write", 32'(rx_ready), 32'd0);
  end

  // Driver: present a byte and hold it until it is taken; rx_valid stays high afterwards.
  task automatic send_byte(input logic [7:0] b);
    bit got = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 8; i++) begin
      if (rx_ready) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (got) @(posedge clk);
    else chk("rx_timeout", 32'd0, 32'd1);
  endtask

  task automatic settle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    // 1: reset values, seen while rst is high and before any edge releases it
    #1;
    chk("rst_stall",   32'(cpu_stall),     32'd1);
    chk("rst_ready",   32'(rx_ready),      32'd1);
    chk("rst_wr",      32'(ram_mem_write), 32'd0);
    chk("rst_rd",      32'(ram_mem_read),  32'd0);
    chk("rst_addr",    32'(ram_addr),      32'd0);
    chk("rst_wdata",   32'(ram_wdata),     32'd0);
    chk("rst_done",    32'(load_done),     32'd0);
    chk("rst_err",     32'(load_error),    32'd0);
    chk("rst_state",   32'(dbg_state),     32'(S_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 2: two-word frame with good checksum, then CPU access through the mux
    base = wr_count;
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hCD); send_byte(8'hAB);
    send_byte(8'hBE);
    settle();
    chk("t2_done",   32'(load_done),  32'd1);
    chk("t2_err",    32'(load_error), 32'd0);
    chk("t2_stall",  32'(cpu_stall),  32'd0);
    chk("t2_nwr",    32'(wr_count - base), 32'd2);
    chk("t2_mem0",   32'(mem[0]), 32'h1234);
    chk("t2_mem1",   32'(mem[1]), 32'hABCD);
    cpu_mem_read = 1'b1; cpu_addr = 8'h01;
    #1;
    chk("t2_cpu_addr", 32'(ram_addr),     32'h01);
    chk("t2_cpu_rd",   32'(ram_mem_read), 32'd1);
    cpu_mem_read = 1'b0; cpu_mem_write = 1'b1; cpu_addr = 8'h40; cpu_wdata = 16'h5A5A;
    #1;
    chk("t2_cpu_wr",    32'(ram_mem_write), 32'd1);
    chk("t2_cpu_wdata", 32'(ram_wdata),     32'h5A5A);
    @(negedge clk);
    cpu_mem_write = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;

    // 3: same frame with a bad checksum
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hCD); send_byte(8'hAB);
    send_byte(8'hBF);
    settle();
    chk("t3_err",   32'(load_error), 32'd1);
    chk("t3_done",  32'(load_done),  32'd0);
    chk("t3_stall", 32'(cpu_stall),  32'd1);
    cpu_mem_read = 1'b1; cpu_addr = 8'h01;
    #1;
    chk("t3_rd_ignored",   32'(ram_mem_read), 32'd0);
    chk("t3_addr_ignored", 32'(ram_addr),     32'd0);
    cpu_mem_read = 1'b0; cpu_addr = 8'h00;

    // 4: junk bytes, then a 256-word frame; word k = {~k, k}, each word sums to FF so CHK = 00
    send_byte(8'h11); send_byte(8'h22);
    settle();
    chk("t4_junk_state", 32'(dbg_state),  32'(S_ERROR));
    chk("t4_junk_err",   32'(load_error), 32'd1);
    base = wr_count;
    send_byte(8'hA5);
    settle();
    chk("t4_err_clr", 32'(load_error), 32'd0);
    send_byte(8'h00);
    for (int k = 0; k < 256; k++) begin
      logic [7:0] kb;
      kb = 8'(k);
      send_byte(kb);
      send_byte(~kb);
    end
    send_byte(8'h00);
    settle();
    chk("t4_done",   32'(load_done), 32'd1);
    chk("t4_nwr",    32'(wr_count - base), 32'd256);
    chk("t4_last",   32'(last_wr_addr), 32'hFF);
    chk("t4_mem0",   32'(mem[0]),   32'hFF00);
    chk("t4_mem128", 32'(mem[128]), 32'h7F80);
    chk("t4_mem255", 32'(mem[255]), 32'h00FF);
    repeat (4) @(negedge clk);
    chk("t4_no_extra", 32'(wr_count - base), 32'd256);

    // 5: valid held high across a frame; magic in DONE stalls the CPU on the next cycle
    base = wr_count;
    send_byte(8'hA5);
    #1;
    chk("t5_stall_next", 32'(cpu_stall), 32'd1);
    chk("t5_done_clr",   32'(load_done), 32'd0);
    chk("t5_state",      32'(dbg_state), 32'(S_COUNT));
    send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    send_byte(8'h65);
    settle();
    chk("t5_done", 32'(load_done), 32'd1);
    chk("t5_nwr",  32'(wr_count - base), 32'd3);
    chk("t5_mem0", 32'(mem[0]), 32'h2211);
    chk("t5_mem1", 32'(mem[1]), 32'h4433);
    chk("t5_mem2", 32'(mem[2]), 32'h6655);

    // 6: reset pulsed while in HI, then a one-word frame
    base = wr_count;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
    settle();
    chk("t6_in_hi", 32'(dbg_state), 32'(S_HI));
    rst = 1'b1;
    #1;
    chk("t6_rst_wr",    32'(ram_mem_write), 32'd0);
    chk("t6_rst_state", 32'(dbg_state),     32'(S_IDLE));
    chk("t6_rst_stall", 32'(cpu_stall),     32'd1);
    @(negedge clk);
    rst = 1'b0;
    chk("t6_nwr_abort", 32'(wr_count - base), 32'd0);
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'hEF); send_byte(8'hBE);
    send_byte(8'hAD);
    settle();
    chk("t6_done",  32'(load_done), 32'd1);
    chk("t6_state", 32'(dbg_state), 32'(S_DONE));
    chk("t6_nwr",   32'(wr_count - base), 32'd1);
    chk("t6_mem0",  32'(mem[0]), 32'hBEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
